// File: rtl/noc_flit_pkg.sv
// Shared flit-link types: flit type encoding, framing FSM states and a constant clog2.
// Flit type occupies the top FLIT_TYPE_BITS of every flit.
package noc_flit_pkg;

  localparam int FLIT_TYPE_BITS = 2;

  typedef enum logic [FLIT_TYPE_BITS-1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    PACKET = 1'b1
  } link_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter: starts full, dec on forward, inc on returned credit.
// Latency 1 cycle (registered count); an inc while full with no dec is dropped and flagged.
module credit_counter
  import noc_flit_pkg::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dec_i,
  input  logic                           inc_i,
  output logic [clog2(BUFFER_SIZE+1)-1:0] count_o,
  output logic                           nonzero_o,
  output logic                           overflow_o
);

  localparam int CW = clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(BUFFER_SIZE);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d    = count_q;
    overflow_o = 1'b0;
    case ({dec_i, inc_i})
      2'b10: count_d = count_q - CW'(1);
      2'b01: begin
        if (count_q == MAX_CNT) begin
          overflow_o = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= MAX_CNT;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/flit_link_tx.sv
// Credit-based link transmitter: checks head/body/tail framing, registers flits onto the link.
// Latency 1 cycle; ready_o falls only when credits run out, so upstream stalls on zero credit.
module flit_link_tx
  import noc_flit_pkg::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FLIT_SIZE-1:0]            data_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic [FLIT_SIZE-1:0]            data_o,
  output logic                            write_o,
  input  logic                            credit_i,
  output logic [clog2(BUFFER_SIZE+1)-1:0] credits_o,
  output logic                            error_o
);

  link_state_t          state_q, state_d;
  logic [FLIT_SIZE-1:0] data_q, data_d;
  logic                 write_q, write_d;
  logic                 error_q, error_d;
  logic                 accept;
  logic                 fwd;
  logic                 frame_err;
  logic                 overflow;
  flit_type_t           flit_type;

  credit_counter #(
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_credit_counter (
    .clk       (clk),
    .rst       (rst),
    .dec_i     (fwd),
    .inc_i     (credit_i),
    .count_o   (credits_o),
    .nonzero_o (ready_o),
    .overflow_o(overflow)
  );

  assign accept    = valid_i & ready_o;
  assign flit_type = flit_type_t'(data_i[FLIT_SIZE-1 -: FLIT_TYPE_BITS]);

  // Out-of-order flits are consumed from upstream but never reach the link.
  always_comb begin
    state_d   = state_q;
    fwd       = 1'b0;
    frame_err = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          case (flit_type)
            HEAD: begin
              fwd     = 1'b1;
              state_d = PACKET;
            end
            HEADTAIL: fwd = 1'b1;
            default:  frame_err = 1'b1;
          endcase
        end
        PACKET: begin
          case (flit_type)
            BODY: fwd = 1'b1;
            TAIL: begin
              fwd     = 1'b1;
              state_d = IDLE;
            end
            default: frame_err = 1'b1;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    write_d = fwd;
    data_d  = fwd ? data_i : data_q;
    error_d = error_q | frame_err | overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      write_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      write_q <= write_d;
      error_q <= error_d;
    end
  end

  assign data_o  = data_q;
  assign write_o = write_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_flit_link_tx.sv
// Directed table-driven bench for flit_link_tx plus hand-written credit drain/refill sequence.
module tb_flit_link_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       write_o;
  logic       credit_i;
  logic [3:0] credits_o;
  logic       error_o;

  int n_tests;
  int n_fail;

  flit_link_tx #(
    .BUFFER_SIZE(8),
    .FLIT_SIZE  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .write_o  (write_o),
    .credit_i (credit_i),
    .credits_o(credits_o),
    .error_o  (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] dat;
    logic       crd;
    logic       wr;
    logic [7:0] dout;
    logic [3:0] cr;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic c,
                     input logic wr, input logic [7:0] dout, input logic [3:0] cr,
                     input logic rdy, input logic err);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d; t.crd = c;
    t.wr = wr; t.dout = dout; t.cr = cr; t.rdy = rdy; t.err = err;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int writes;
    int extra;
    bit got;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid_i  = 1'b0;
    data_i   = 8'h00;
    credit_i = 1'b0;

    //   rst v  data  c | wr dout  cr rdy err
    add(1, 0, 8'h00, 0,  0, 8'h00, 8, 1, 0);  // 0 reset state
    add(0, 1, 8'h01, 0,  1, 8'h01, 7, 1, 0);  // 1 HEAD
    add(0, 1, 8'h42, 0,  1, 8'h42, 6, 1, 0);  // 2 BODY
    add(0, 1, 8'h43, 0,  1, 8'h43, 5, 1, 0);  // 3 BODY
    add(0, 1, 8'h84, 0,  1, 8'h84, 4, 1, 0);  // 4 TAIL
    add(0, 0, 8'h00, 0,  0, 8'h84, 4, 1, 0);  // 5 idle, data held
    add(0, 0, 8'h00, 1,  0, 8'h84, 5, 1, 0);  // 6-9 refill to 8
    add(0, 0, 8'h00, 1,  0, 8'h84, 6, 1, 0);
    add(0, 0, 8'h00, 1,  0, 8'h84, 7, 1, 0);
    add(0, 0, 8'h00, 1,  0, 8'h84, 8, 1, 0);
    for (int k = 0; k < 8; k++) begin          // 10-17 HEADTAIL burst drains credits
      add(0, 1, 8'hC0 + 8'(k), 0, 1, 8'hC0 + 8'(k), 4'(7 - k), (k != 7), 0);
    end
    add(0, 1, 8'hC8, 0,  0, 8'hC7, 0, 0, 0);  // 18 stalled
    add(0, 1, 8'hC9, 0,  0, 8'hC7, 0, 0, 0);  // 19 stalled
    add(0, 1, 8'hC9, 1,  0, 8'hC7, 1, 1, 0);  // 20 credit at zero: no same-cycle accept
    add(0, 1, 8'hC9, 0,  1, 8'hC9, 0, 0, 0);  // 21 one more write
    add(0, 0, 8'h00, 1,  0, 8'hC9, 1, 1, 0);  // 22 credits=1
    add(0, 1, 8'hCA, 1,  1, 8'hCA, 1, 1, 0);  // 23 forward + credit: stays 1
    add(0, 1, 8'h55, 0,  0, 8'hCA, 1, 1, 1);  // 24 BODY in IDLE dropped
    add(0, 1, 8'hCB, 0,  1, 8'hCB, 0, 0, 1);  // 25 HEADTAIL forwarded, error sticky
    add(1, 0, 8'h00, 0,  0, 8'h00, 8, 1, 0);  // 26 reset clears
    add(0, 0, 8'h00, 0,  0, 8'h00, 8, 1, 0);  // 27
    add(0, 0, 8'h00, 1,  0, 8'h00, 8, 1, 1);  // 28 credit overflow
    add(1, 0, 8'h00, 0,  0, 8'h00, 8, 1, 0);  // 29 reset
    add(0, 1, 8'h0D, 0,  1, 8'h0D, 7, 1, 0);  // 30 HEAD
    add(0, 1, 8'h4E, 0,  1, 8'h4E, 6, 1, 0);  // 31 BODY
    add(1, 0, 8'h00, 0,  0, 8'h00, 8, 1, 0);  // 32 reset mid-packet
    add(0, 1, 8'h4F, 0,  0, 8'h00, 8, 1, 1);  // 33 BODY after reset flagged
    add(0, 1, 8'h10, 0,  1, 8'h10, 7, 1, 1);  // 34 HEAD forwarded
    add(0, 1, 8'h11, 0,  0, 8'h10, 7, 1, 1);  // 35 HEAD in PACKET dropped
    add(0, 1, 8'h92, 0,  1, 8'h92, 6, 1, 1);  // 36 TAIL forwarded

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst      = vq[i].rst;
      valid_i  = vq[i].vld;
      data_i   = vq[i].dat;
      credit_i = vq[i].crd;
      #1;
      // ready_o must reflect only the registered count, not this cycle's inputs
      if (i > 0 && !vq[i].rst) chk("ready_pre", i, int'(ready_o), int'(vq[i-1].rdy));
      @(posedge clk);
      #1;
      chk("write_o",   i, int'(write_o),   int'(vq[i].wr));
      chk("data_o",    i, int'(data_o),    int'(vq[i].dout));
      chk("credits_o", i, int'(credits_o), int'(vq[i].cr));
      chk("ready_o",   i, int'(ready_o),   int'(vq[i].rdy));
      chk("error_o",   i, int'(error_o),   int'(vq[i].err));
    end

    // Hand sequence: hold valid across a credit drain, then refill one credit.
    @(negedge clk);
    rst      = 1'b1;
    valid_i  = 1'b0;
    credit_i = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'hC5;
    writes  = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      writes += int'(write_o);
    end
    chk("drain_writes",  100, writes,          8);
    chk("drain_credits", 100, int'(credits_o), 0);
    chk("drain_ready",   100, int'(ready_o),   0);
    @(negedge clk);
    credit_i = 1'b1;
    @(negedge clk);
    credit_i = 1'b0;
    chk("refill_ready", 101, int'(ready_o), 1);
    got   = 1'b0;
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (write_o) begin
        if (got) extra++;
        got = 1'b1;
      end
    end
    chk("refill_write_seen",  101, int'(got), 1);
    chk("refill_extra_write", 101, extra,     0);
    chk("refill_error",       101, int'(error_o), 0);
    valid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_link_tx.md
# flit_link_tx

Credit-based link transmitter driving a downstream router input `circular_buffer`. It accepts flits from the local output stage over a valid/ready handshake and forwards them one per cycle on a registered write strobe. It tracks free downstream buffer slots with a credit counter, replenished by a one-cycle credit pulse each time the downstream buffer pops a flit. It also checks head/body/tail packet framing and drops out-of-order flits.

## Interface
- `BUFFER_SIZE`, 8: depth of the downstream buffer; initial and maximum credit count.
- `FLIT_SIZE`, 8: flit width in bits; the top 2 bits carry the flit type.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `data_i`  in  FLIT_SIZE: flit from the upstream stage.
- `valid_i`  in  1: `data_i` is valid.
- `ready_o`  out  1: the block can take a flit this cycle.
- `data_o`  out  FLIT_SIZE: flit to the downstream buffer (`data_i` of the buffer).
- `write_o`  out  1: write strobe to the downstream buffer (`write_i` of the buffer).
- `credit_i`  in  1: one-cycle pulse; the downstream buffer freed one slot.
- `credits_o`  out  clog2(BUFFER_SIZE+1): current credit count.
- `error_o`  out  1: sticky framing or credit-overflow error.

## Operation
- Flit type is `data_i[FLIT_SIZE-1:FLIT_SIZE-2]`. Encodings: HEAD=00, BODY=01, TAIL=10, HEADTAIL=11.
- `ready_o = (credits != 0)`. It is combinational from the credit register only and never depends on `valid_i`.
- A flit is accepted when `valid_i & ready_o`. Every accepted flit is either forwarded or dropped.
- Framing FSM, states IDLE and PACKET:
  - IDLE: HEAD → forward, go to PACKET. HEADTAIL → forward, stay in IDLE. BODY or TAIL → drop, set `error_o`, stay in IDLE.
  - PACKET: BODY → forward, stay. TAIL → forward, go to IDLE. HEAD or HEADTAIL → drop, set `error_o`, stay in PACKET.
  - The FSM advances only on an accepted flit.
- A forwarded flit consumes one credit. A dropped flit consumes none and produces no write.
- Credit update: `credits_next = credits - fwd + credit_i`, where `fwd` = 1 when a flit is forwarded this cycle.
  - Simultaneous forward and `credit_i`: count unchanged.
- Overflow: `credit_i` while `credits == BUFFER_SIZE` and no forward → pulse ignored, count stays at BUFFER_SIZE, `error_o` set.
- `error_o` is sticky and is cleared only by `rst`.
- Reset values:
  - `credits_o` = BUFFER_SIZE
  - `ready_o` = 1
  - `write_o` = 0
  - `data_o` = 0
  - `error_o` = 0
  - FSM = IDLE
- Reset asserted mid-packet returns the block to IDLE with full credits. Flits in flight are lost, and the downstream buffer is reset on the same `rst`.

## Timing
- Latency is 1 cycle. A flit accepted at edge N appears on `data_o` with `write_o`=1 during cycle N+1.
- `write_o` is asserted for exactly one cycle per forwarded flit. Back-to-back accepts give back-to-back writes.
- `data_o` holds its last value when `write_o`=0.
- `credit_i` arriving at edge N is visible on `credits_o` and `ready_o` from N+1; there is no same-cycle bypass.
- With `credits == 0`, `ready_o` stays low the whole cycle, even if `credit_i` is high in that cycle.
- With `credits == 1` and a forward plus `credit_i` in the same cycle, `ready_o` stays high in the next cycle.
- The downstream buffer must never see `write_o` while full. This is guaranteed because credits never exceed BUFFER_SIZE.

## Structure
- Package `noc_flit_pkg`:
  - `flit_type_t` enum (HEAD, BODY, TAIL, HEADTAIL)
  - `FLIT_TYPE_BITS` = 2
  - shared clog2 function
- Sub-module `credit_counter`:
  - Parameter BUFFER_SIZE.
  - Inputs: `clk`, `rst`, `dec_i`, `inc_i`.
  - Outputs: `count_o`, `nonzero_o`, `overflow_o`.
  - Holds the saturating up/down counter and its overflow detect.
- Top level holds the framing FSM, the output register and the error flag.

## Test plan
- Reset, then HEAD, BODY, BODY, TAIL on consecutive cycles, `credit_i`=0 → four writes in cycles 1–4 with matching data, `credits_o` 8→4, FSM back in IDLE, `error_o`=0.
- Hold `valid_i`=1 with 10 HEADTAIL flits, no credits returned → exactly 8 writes, `ready_o`=0 after the 8th accept, `credits_o`=0. One `credit_i` pulse → `ready_o`=1 the next cycle and one more write.
- `credits_o`=1 with a forward and `credit_i` in the same cycle → `credits_o` stays 1, `ready_o` stays 1.
- In IDLE, send BODY → no write, `credits_o` unchanged, `error_o`=1. Then send HEADTAIL → forwarded, `error_o` still 1.
- At `credits_o`=8, pulse `credit_i` with no traffic → `credits_o` stays 8, `error_o`=1.
- Assert `rst` after HEAD and one BODY → `credits_o`=8, `write_o`=0, FSM IDLE. A following BODY is flagged as an error; a following HEAD is forwarded.
